br_redirect_ctrl: RTL

- Consumer end of the branch comparator. Takes o_br_less/o_br_equal from brc for the instruction in EX and decides taken/not-taken for BEQ/BNE/BLT/BGE/BLTU/BGEU/JAL/JALR.
- Drives the brc signed/unsigned select.
- Under static not-taken prediction, a taken branch or jump issues a PC redirect to fetch over a valid/ready handshake, then flushes IF/ID and ID/EX until fetch accepts and drains.
- Sits between EX and IF in the pipelined non-forwarding RV32I core.

---
 rtl/br_redirect_ctrl_pkg.sv | 53 +++++
 rtl/br_redirect_ctrl.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/br_redirect_ctrl_pkg.sv
// Shared definitions for the branch-resolution / redirect controller.
// Holds the branch funct3 encodings, the redirect FSM state type, and the
// taken-decision helpers. The helpers are functions so that decode-stage
// tooling can reuse the same decision logic.
package br_redirect_ctrl_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REDIRECT = 2'd1,
    DRAIN    = 2'd2
  } brc_state_e;

  // 010/011 are not branch encodings in RV32I.
  function automatic logic br_f3_illegal(input logic [2:0] f3);
    return (f3 == 3'b010) || (f3 == 3'b011);
  endfunction

  // Signed compare only for BLT/BGE; everything else uses unsigned.
  function automatic logic br_signed(input logic [2:0] f3);
    return (f3 == F3_BLT) || (f3 == F3_BGE);
  endfunction

  // Taken decision; jumps win over a (malformed) simultaneous branch flag.
  function automatic logic br_take(input logic       is_br,
                                   input logic       is_jal,
                                   input logic       is_jalr,
                                   input logic [2:0] f3,
                                   input logic       less,
                                   input logic       equal);
    logic take;
    take = 1'b0;
    if (is_jal || is_jalr) begin
      take = 1'b1;
    end else if (is_br) begin
      case (f3)
        F3_BEQ:           take = equal;
        F3_BNE:           take = !equal;
        F3_BLT, F3_BLTU:  take = less;
        F3_BGE, F3_BGEU:  take = !less;
        default:          take = 1'b0;
      endcase
    end
    return take;
  endfunction

endpackage

// File: rtl/br_redirect_ctrl.sv
// Branch/jump resolution and fetch redirect controller (EX -> IF).
// Resolves BEQ/BNE/BLT/BGE/BLTU/BGEU/JAL/JALR from the comparator flags,
// selects comparator signedness, and under static not-taken prediction
// issues a valid/ready redirect to fetch while flushing IF/ID and ID/EX.
//
// Ports:
//   i_clk, i_reset            clock, synchronous active-high reset
//   i_ex_*                    EX-stage instruction info and ALU target
//   i_br_less, i_br_equal     comparator results
//   o_br_un                   comparator select (1 = signed)
//   o_redirect_valid/_pc      redirect request, i_redirect_ready accepts
//   o_flush_ifid/_idex        pipeline squash
//   o_misalign, o_illegal_br  one-cycle error pulses
//   o_br_count, o_taken_count statistics, wrap modulo 2^CNT_W
//
// state    | meaning
// IDLE     | resolving whatever is in EX
// REDIRECT | redirect offered to fetch, pipeline flushed
// DRAIN    | redirect accepted, flushing in-flight fetches
module br_redirect_ctrl #(
  parameter int XLEN         = 32,
  parameter int DRAIN_CYCLES = 1,
  parameter int CNT_W        = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_ex_valid,
  input  logic             i_ex_is_br,
  input  logic             i_ex_is_jal,
  input  logic             i_ex_is_jalr,
  input  logic [2:0]       i_ex_funct3,
  input  logic             i_br_less,
  input  logic             i_br_equal,
  input  logic [XLEN-1:0]  i_ex_target,
  output logic             o_br_un,
  output logic             o_redirect_valid,
  output logic [XLEN-1:0]  o_redirect_pc,
  input  logic             i_redirect_ready,
  output logic             o_flush_ifid,
  output logic             o_flush_idex,
  output logic             o_misalign,
  output logic             o_illegal_br,
  output logic [CNT_W-1:0] o_br_count,
  output logic [CNT_W-1:0] o_taken_count
);
  import br_redirect_ctrl_pkg::*;

  // Drain counter counts down from DRAIN_CYCLES-1 to 0.
  localparam int DW         = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam int DRAIN_LOAD = (DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0;

  brc_state_e       state_q, state_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic [DW-1:0]    drain_q, drain_d;
  logic             misalign_q, misalign_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
  logic [CNT_W-1:0] tk_cnt_q, tk_cnt_d;

  logic             ex_xfer;
  logic             take;
  logic [XLEN-1:0]  target;

  assign o_br_un = br_signed(i_ex_funct3);

  always_comb begin
    ex_xfer = i_ex_valid && (i_ex_is_br || i_ex_is_jal || i_ex_is_jalr);
    take    = i_ex_valid && br_take(i_ex_is_br, i_ex_is_jal, i_ex_is_jalr,
                                    i_ex_funct3, i_br_less, i_br_equal);
    target  = i_ex_target;
    if (i_ex_is_jalr) target[0] = 1'b0;
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    drain_d    = drain_q;
    misalign_d = 1'b0;
    illegal_d  = 1'b0;
    br_cnt_d   = br_cnt_q;
    tk_cnt_d   = tk_cnt_q;
    case (state_q)
      IDLE: begin
        if (ex_xfer) begin
          br_cnt_d = br_cnt_q + CNT_W'(1);
          if (i_ex_is_br && !i_ex_is_jal && !i_ex_is_jalr && br_f3_illegal(i_ex_funct3))
            illegal_d = 1'b1;
          if (take) begin
            // Bit 0 is never fetched; bit 1 set means a half-word target.
            if (target[1]) begin
              misalign_d = 1'b1;
            end else begin
              pc_d     = target;
              tk_cnt_d = tk_cnt_q + CNT_W'(1);
              state_d  = REDIRECT;
            end
          end
        end
      end
      REDIRECT: begin
        if (i_redirect_ready) begin
          if (DRAIN_CYCLES > 0) begin
            state_d = DRAIN;
            drain_d = DW'(DRAIN_LOAD);
          end else begin
            state_d = IDLE;
          end
        end
      end
      DRAIN: begin
        if (drain_q == '0) state_d = IDLE;
        else               drain_d = drain_q - DW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= IDLE;
      pc_q       <= '0;
      drain_q    <= '0;
      misalign_q <= 1'b0;
      illegal_q  <= 1'b0;
      br_cnt_q   <= '0;
      tk_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      drain_q    <= drain_d;
      misalign_q <= misalign_d;
      illegal_q  <= illegal_d;
      br_cnt_q   <= br_cnt_d;
      tk_cnt_q   <= tk_cnt_d;
    end
  end

  // Handshake and flush outputs decode directly from the state register.
  assign o_redirect_valid = (state_q == REDIRECT);
  assign o_flush_ifid     = (state_q != IDLE);
  assign o_flush_idex     = (state_q != IDLE);
  assign o_redirect_pc    = pc_q;
  assign o_misalign       = misalign_q;
  assign o_illegal_br     = illegal_q;
  assign o_br_count       = br_cnt_q;
  assign o_taken_count    = tk_cnt_q;

endmodule
